// File: rtl/regport_arbiter_pkg.sv
// Shared types and default widths for the two-requester register-port arbiter.
package regport_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_rec_t;

endpackage

// File: rtl/regport_arbiter_if.sv
// Requester-side bundle: two request channels and their read-response channels.
interface regport_arbiter_if
  import regport_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/regport_rr_pick.sv
// Two-way round-robin pick: blocked requesters drop out, the favoured one wins a tie.
module regport_rr_pick
  import regport_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic [1:0] block,
  input  prio_t      ptr,
  output logic [1:0] grant
);

  logic [1:0] elig;

  assign elig = valid & ~block;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = (ptr == PRIO0) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regport_arbiter.sv
// Arbitrates two requesters onto one register-file read port and one registered write port.
// Define REGPORT_ARB_BYPASS_EN to forward in-flight write data instead of stalling hazarding reads.
module regport_arbiter
  import regport_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  regport_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd1_data,
  output logic [ADDR_W-1:0] rf_wr1,
  output logic [DATA_W-1:0] rf_wr1_data,
  output logic              rf_wr1_enable
);

  prio_t             ptr_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        hazard;
  logic [1:0]        block;
  logic [1:0]        grant;
  logic              sel;
  logic              rd_idx;
  logic              any_grant;
  logic              rd_go;
  logic              wr_go;
  logic [DATA_W-1:0] rd_data;

  assign req_valid    = {bus.req1_valid, bus.req0_valid};
  assign req_we       = {bus.req1_we, bus.req0_we};
  assign req_addr[0]  = bus.req0_addr;
  assign req_addr[1]  = bus.req1_addr;
  assign req_wdata[0] = bus.req0_wdata;
  assign req_wdata[1] = bus.req1_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hazard
      // A read colliding with the write currently on the rf port would see stale data.
      assign hazard[gi] = !req_we[gi] && wr_en_reg && (req_addr[gi] == wr_addr_reg);
`ifdef REGPORT_ARB_BYPASS_EN
      assign block[gi] = 1'b0;
`else
      assign block[gi] = hazard[gi];
`endif
    end
  endgenerate

  regport_rr_pick u_pick (
    .valid (req_valid),
    .block (block),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  always_comb begin
    sel = (ptr_reg == PRIO1);
    if (grant[0]) begin
      sel = 1'b0;
    end else if (grant[1]) begin
      sel = 1'b1;
    end
  end

  assign any_grant = |grant;
  assign rd_go     = any_grant && !req_we[sel];
  assign wr_go     = any_grant &&  req_we[sel];
  assign rd_idx    = rd_go ? sel : (ptr_reg == PRIO1);
  assign rf_rd1    = req_addr[rd_idx];

  // Without bypass a granted read never hazards, so this select only matters in the bypass build.
  assign rd_data = hazard[sel] ? wr_data_reg : rf_rd1_data;

  assign bus.req0_ready = grant[0] && !reset;
  assign bus.req1_ready = grant[1] && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg     <= PRIO0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      case (ptr_reg)
        PRIO0:   if (grant[0]) ptr_reg <= PRIO1;
        PRIO1:   if (grant[1]) ptr_reg <= PRIO0;
        default: ptr_reg <= PRIO0;
      endcase
      if (grant == 2'b10) begin
        ptr_reg <= PRIO0;
      end else if (grant == 2'b01) begin
        ptr_reg <= PRIO1;
      end
      wr_en_reg <= wr_go;
      if (wr_go) begin
        wr_addr_reg <= req_addr[sel];
        wr_data_reg <= req_wdata[sel];
      end
    end
  end

  assign rf_wr1        = wr_addr_reg;
  assign rf_wr1_data   = wr_data_reg;
  assign rf_wr1_enable = wr_en_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= rd_go && (sel == 1'(gi));
          if (rd_go && (sel == 1'(gi))) begin
            data_reg <= rd_data;
          end
        end
      end
    end
  endgenerate

  assign bus.rsp0_valid = g_rsp[0].valid_reg;
  assign bus.rsp0_data  = g_rsp[0].data_reg;
  assign bus.rsp1_valid = g_rsp[1].valid_reg;
  assign bus.rsp1_data  = g_rsp[1].data_reg;

endmodule
